// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx serializer among NREQ byte requesters.
// One byte is captured per grant. tx_send pulses for a single cycle, and tx_data
// stays constant for the rest of the frame and any trailing gap.
module uart_tx_sched #(
    parameter int NREQ         = 4,
    parameter int FRAME_CYCLES = 12,
    parameter int GAP_CYCLES   = 0,
    parameter int IDW          = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]     req_ack,
    output logic                tx_send,
    output logic [7:0]          tx_data,
    output logic                tx_busy,
    output logic [IDW-1:0]      grant_id
);
    localparam int CW = $clog2(FRAME_CYCLES + GAP_CYCLES + 1);
    localparam logic [CW-1:0]  FLUSH_LOAD = CW'(FRAME_CYCLES - 1);
    localparam logic [CW-1:0]  WAIT_LOAD  = CW'(FRAME_CYCLES + GAP_CYCLES - 2);
    localparam logic [IDW-1:0] ID_RST     = IDW'(NREQ - 1);

    typedef enum logic [1:0] {FLUSH, IDLE, SEND, WAIT} state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [NREQ-1:0]   ack_n;
    logic              send_n, busy_n;
    logic [7:0]        data_n;
    logic [IDW-1:0]    gid_n;

    logic              win_found;
    logic [IDW-1:0]    win_id;
    logic [IDW-1:0]    cand;
    int                rr_idx;

    // Round-robin search starting one past the last grant, wrapping modulo NREQ
    always_comb begin
        win_found = 1'b0;
        win_id    = grant_id;
        rr_idx    = 0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            rr_idx = (int'(grant_id) + k) % NREQ;
            cand   = IDW'(rr_idx);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    // Next-state and next-output logic; every output is registered below
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ack_n   = '0;
        send_n  = 1'b0;
        data_n  = tx_data;
        busy_n  = tx_busy;
        gid_n   = grant_id;
        case (state)
            // The serializer has no reset, so wait out a frame that may still be in flight
            FLUSH: begin
                if (cnt == '0) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            IDLE: begin
                if (win_found) begin
                    state_n = SEND;
                    send_n  = 1'b1;
                    ack_n   = NREQ'(1) << win_id;
                    data_n  = 8'(req_data >> {win_id, 3'b000});
                    gid_n   = win_id;
                    busy_n  = 1'b1;
                end
            end
            SEND: begin
                state_n = WAIT;
                cnt_n   = WAIT_LOAD;
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: state_n = FLUSH;
        endcase
    end

    // State, counter and output registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FLUSH;
            cnt      <= FLUSH_LOAD;
            req_ack  <= '0;
            tx_send  <= 1'b0;
            tx_data  <= 8'h00;
            tx_busy  <= 1'b1;
            grant_id <= ID_RST;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            req_ack  <= ack_n;
            tx_send  <= send_n;
            tx_data  <= data_n;
            tx_busy  <= busy_n;
            grant_id <= gid_n;
        end
    end
endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: a 4-requester instance with random producers and a
// 1-requester instance with a 3-cycle gap and continuous valid. Both are checked
// against a timing model: a send is legal from cycle "earliest" onward, and every
// send pushes "earliest" one send period further out.
module tb_uart_tx_sched;
    localparam int NREQ = 4;
    localparam int F    = 12;
    localparam int G1   = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NREQ-1:0]   req_valid = '0;
    logic [8*NREQ-1:0] req_data  = '0;
    logic [NREQ-1:0]   req_ack;
    logic              tx_send, tx_busy;
    logic [7:0]        tx_data;
    logic [1:0]        grant_id;

    logic       rv1 = 1'b1;
    logic [7:0] rd1 = 8'h00;
    logic       ack1, send1, busy1, gid1;
    logic [7:0] data1;

    uart_tx_sched #(.NREQ(NREQ), .FRAME_CYCLES(F), .GAP_CYCLES(0)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ack(req_ack), .tx_send(tx_send), .tx_data(tx_data),
        .tx_busy(tx_busy), .grant_id(grant_id));

    uart_tx_sched #(.NREQ(1), .FRAME_CYCLES(F), .GAP_CYCLES(G1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(rv1), .req_data(rd1),
        .req_ack(ack1), .tx_send(send1), .tx_data(data1),
        .tx_busy(busy1), .grant_id(gid1));

    int tests = 0;
    int fails = 0;

    // model state
    int n, earliest, ptr, last_send, earliest1, mode;
    logic [7:0]        exp_data, exp_data1;
    logic [NREQ-1:0]   pv;
    logic [8*NREQ-1:0] pd;
    logic              pv1;
    logic [7:0]        pd1;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, n);
        end
    endtask

    task automatic chk_reset(string tag);
        chk({tag, ".req_ack"},  32'(req_ack),  32'h0);
        chk({tag, ".tx_send"},  32'(tx_send),  32'h0);
        chk({tag, ".tx_data"},  32'(tx_data),  32'h0);
        chk({tag, ".tx_busy"},  32'(tx_busy),  32'h1);
        chk({tag, ".grant_id"}, 32'(grant_id), 32'(NREQ - 1));
        chk({tag, ".u1_send"},  32'(send1),    32'h0);
        chk({tag, ".u1_data"},  32'(data1),    32'h0);
        chk({tag, ".u1_busy"},  32'(busy1),    32'h1);
        chk({tag, ".u1_ack"},   32'(ack1),     32'h0);
    endtask

    task automatic reset_model();
        n         = 0;
        earliest  = F + 1;
        earliest1 = F + 1;
        ptr       = NREQ - 1;
        last_send = -100;
        exp_data  = 8'h00;
        exp_data1 = 8'h00;
        pv  = req_valid;
        pd  = req_data;
        pv1 = rv1;
        pd1 = rd1;
    endtask

    // Producers: mode 0 random raise/withdraw, mode 1 keep current requesters
    // re-raising after ack, mode 2 every requester always valid
    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (req_ack[i]) begin
                req_valid[i] = (mode != 0) || ($urandom_range(0, 1) == 1);
                req_data[8*i +: 8] = 8'($urandom);
            end else if (mode == 0) begin
                if (req_valid[i] && $urandom_range(0, 19) == 0)
                    req_valid[i] = 1'b0;
                else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    req_valid[i] = 1'b1;
                    req_data[8*i +: 8] = 8'($urandom);
                end
            end else if (mode == 2 && !req_valid[i]) begin
                req_valid[i] = 1'b1;
                req_data[8*i +: 8] = 8'($urandom);
            end
        end
        if (ack1) rd1 = 8'($urandom);
        pv  = req_valid;
        pd  = req_data;
        pv1 = rv1;
        pd1 = rd1;
    endtask

    // One clock: observe outputs of posedge n against the model, then drive edge n+1
    task automatic step();
        logic            exp_send, exp_send1;
        logic [NREQ-1:0] exp_ack;
        int              w;
        @(negedge clk);
        n++;
        exp_send = (n >= earliest) && (pv != '0);
        exp_ack  = '0;
        if (exp_send) begin
            w = -1;
            for (int k = 1; k <= NREQ; k++)
                if (w < 0 && pv[(ptr + k) % NREQ]) w = (ptr + k) % NREQ;
            ptr        = w;
            exp_ack[w] = 1'b1;
            exp_data   = pd[8*w +: 8];
            earliest   = n + F + 1;
            last_send  = n;
        end
        chk("tx_send",  32'(tx_send),  32'(exp_send));
        chk("req_ack",  32'(req_ack),  32'(exp_ack));
        chk("tx_data",  32'(tx_data),  32'(exp_data));
        chk("tx_busy",  32'(tx_busy),  32'(n < earliest - 1));
        chk("grant_id", 32'(grant_id), 32'(ptr));

        exp_send1 = (n >= earliest1) && pv1;
        if (exp_send1) begin
            exp_data1 = pd1;
            earliest1 = n + F + G1 + 1;
        end
        chk("u1_send", 32'(send1), 32'(exp_send1));
        chk("u1_ack",  32'(ack1),  32'(exp_send1));
        chk("u1_data", 32'(data1), 32'(exp_data1));
        chk("u1_busy", 32'(busy1), 32'(n < earliest1 - 1));
        chk("u1_gid",  32'(gid1),  32'h0);
        drive();
    endtask

    initial begin
        int guard;
        mode = 1;
        req_valid = 4'b0001;
        req_data  = 32'(8'($urandom));
        rd1       = 8'($urandom);
        repeat (3) @(negedge clk);
        chk_reset("reset");

        // release with requester 0 already waiting: first grant only after flush
        rst = 1'b0;
        reset_model();
        repeat (40) step();

        // all four requesters held: strict rotation, one send every F+1 cycles
        mode = 2;
        repeat (80) step();

        mode = 0;
        repeat (400) step();

        // reset five cycles into a frame's wait phase, with requests pending
        mode  = 2;
        guard = 0;
        while (!(last_send > 0 && n == last_send + 6) && guard < 100) begin
            step();
            guard++;
        end
        chk("wait_reached", 32'(guard < 100), 32'h1);
        #2 rst = 1'b1;
        #1 chk_reset("async_rst");
        @(negedge clk);
        chk_reset("rst_held");
        rst = 1'b0;
        reset_model();
        repeat (60) step();

        mode = 0;
        repeat (150) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
